// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported data memory between the CPU MEM
// stage (default priority) and a DMA port. One access per cycle, CPU stalls
// when it loses, DMA is forced through after STARVE_LIMIT consecutive CPU wins
// unless the CPU holds m_lock. Read data is steered back to its owner by a
// tag pipeline matched to the memory read latency.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 17,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned RD_LATENCY   = 1
) (
    input  logic              clock,
    input  logic              nreset,
    input  logic              m_req,
    input  logic              m_we,
    input  logic              m_lock,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_stall,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0]            starve_cnt;
    logic                  force_dma;
    logic                  grant_d;
    logic                  grant_m;
    logic [RD_LATENCY-1:0] tag_valid;
    logic [RD_LATENCY-1:0] tag_owner;

    // Grant decision: CPU wins by default, DMA wins when CPU is idle or when
    // the starvation counter forces it and the CPU is not holding its lock.
    always_comb begin
        force_dma = (starve_cnt == LIMIT);
        grant_d   = d_req & (~m_req | (force_dma & ~m_lock));
        grant_m   = m_req & ~grant_d;
        m_stall   = m_req & ~grant_m;
        d_gnt     = grant_d;
    end

    // Memory-side mux: drive the granted port, all zero when idle.
    always_comb begin
        mem_en    = grant_m | grant_d;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_d) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (grant_m) begin
            mem_we    = m_we;
            mem_addr  = m_addr;
            mem_wdata = m_wdata;
        end
    end

    // Starvation counter: counts CPU wins while DMA waits, saturates at the
    // limit (only reachable while m_lock holds off the forced grant).
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            starve_cnt <= '0;
        end else if (!d_req || grant_d) begin
            starve_cnt <= '0;
        end else if (grant_m && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Tag pipeline: one {valid, owner} stage per cycle of read latency.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid[0] <= mem_en & ~mem_we;
            tag_owner[0] <= grant_d;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_owner[i] <= tag_owner[i-1];
            end
        end
    end

    // Response routing from the last tag stage; non-owner sees zero data.
    always_comb begin
        m_rvalid = tag_valid[RD_LATENCY-1] & ~tag_owner[RD_LATENCY-1];
        d_rvalid = tag_valid[RD_LATENCY-1] &  tag_owner[RD_LATENCY-1];
        m_rdata  = m_rvalid ? mem_rdata : '0;
        d_rdata  = d_rvalid ? mem_rdata : '0;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported data memory behind the memory I/O unit between two requesters:
  - the MEM pipeline stage (CPU port, default priority);
  - a block-transfer/framebuffer DMA port.
- Issues at most one access per cycle.
- Stalls the losing CPU request, and forces a DMA grant after a bounded number of consecutive CPU wins so DMA cannot starve.
- Routes read data back to the owner using a latency-tracked tag pipeline.
- Sits between the MEM stage's address/data outputs and the memory I/O unit; its m_stall feeds the hazard/stall logic.

Parameters:
- ADDR_W, 17, address width (bit 16 = framebuffer page bit).
- DATA_W, 12, memory data width.
- STARVE_LIMIT, 4, consecutive CPU grants with DMA pending before DMA is forced (legal range 1..15).
- RD_LATENCY, 1, cycles from mem_en to valid mem_rdata (legal range 1..4).

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- m_req  in  1  CPU access request.
- m_we  in  1  CPU write enable (1 = store).
- m_lock  in  1  CPU holds priority (multi-byte push/pop); suppresses forced DMA grant.
- m_addr  in  ADDR_W  CPU address.
- m_wdata  in  DATA_W  CPU store data.
- m_stall  out  1  CPU request not granted this cycle.
- m_rvalid  out  1  CPU read data valid.
- m_rdata  out  DATA_W  CPU read data.
- d_req  in  1  DMA request.
- d_we  in  1  DMA write enable.
- d_addr  in  ADDR_W  DMA address.
- d_wdata  in  DATA_W  DMA store data.
- d_gnt  out  1  DMA request accepted this cycle.
- d_rvalid  out  1  DMA read data valid.
- d_rdata  out  DATA_W  DMA read data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid RD_LATENCY cycles after a read issue.

Behaviour:
- Grant decision is combinational each cycle; the memory side is driven in the same cycle as the grant, so there is zero added latency for the CPU.
- grant_d = d_req & (~m_req | (force & ~m_lock)), where force = (starve_cnt == STARVE_LIMIT).
- grant_m = m_req & ~grant_d.
- m_stall = m_req & ~grant_m. d_gnt = grant_d. The DMA port holds d_req/d_addr/d_wdata stable until d_gnt.
- mem_en = grant_m | grant_d. mem_we/mem_addr/mem_wdata are muxed from the granted port; they are all zero when mem_en = 0.
- starve_cnt (4-bit):
  - clears when d_req = 0 or grant_d = 1;
  - increments when grant_m & d_req;
  - saturates at STARVE_LIMIT while m_lock holds it off.
- Tag pipeline: RD_LATENCY stages of {valid, owner}. Stage 0 loads {mem_en & ~mem_we, grant_d} and shifts every cycle.
- At the last stage, if valid:
  - m_rvalid = ~owner, d_rvalid = owner;
  - the owning port's rdata = mem_rdata, and the other port's rdata = 0.
- rvalid outputs are pulses, combinational from the last tag stage.
- Writes generate no response.
- Back-to-back reads from alternating owners return in issue order, one per cycle.
- Simultaneous m_req & d_req with starve_cnt < STARVE_LIMIT: CPU wins, DMA waits, counter increments.
- m_req with no d_req: no stall, counter stays 0.
- Reset (async, nreset = 0): starve_cnt = 0 and all tag stages are invalid.
  - Outputs while in reset: m_rvalid = d_rvalid = 0, m_rdata = d_rdata = 0.
  - Combinational outputs (m_stall, d_gnt, mem_*) still follow the request inputs during reset; requesters keep req low while reset is active.
- Reset mid-read: in-flight responses are discarded; no rvalid follows for them after release.

Test Plan:
- CPU only: m_req = 1, m_we = 0, m_addr = 0x00100, RD_LATENCY = 1, mem_rdata = 0x0A5 → mem_en = 1, m_stall = 0 at t; m_rvalid = 1, m_rdata = 0x0A5 at t+1; d_rvalid = 0.
- Contention, STARVE_LIMIT = 4: m_req and d_req held 6 cycles → cycles 0-3 CPU granted; cycle 4 d_gnt = 1, m_stall = 1, mem_addr = d_addr; cycle 5 CPU granted, starve_cnt = 0 (cleared by the cycle-4 DMA grant).
- Lock: same as previous with m_lock = 1 → CPU granted all 6 cycles, d_gnt = 0, starve_cnt stays 4; drop m_lock → DMA granted next cycle.
- Interleaved reads, RD_LATENCY = 3: CPU read 0x00010, then DMA read 0x10020 (DMA issued on its forced grant) → responses 3 cycles after each issue, in issue order, each routed only to its owner.
- Writes: DMA write d_addr = 0x10004, d_wdata = 0x3C1 with no m_req → mem_we = 1, mem_wdata = 0x3C1, d_gnt = 1; no rvalid on either port.
- Reset mid-flight: CPU read issued, nreset pulsed low before the response → m_rvalid never asserts; starve_cnt = 0 after release.
